// File: rtl/fft_twiddle_seq.sv
// fft_twiddle_seq - butterfly schedule sequencer for the 16-point radix-2 DIF FFT.
// Walks 4 stages x 8 butterflies, fetches each twiddle from an external LUT and
// presents {stage, top, bot, twiddle, last} as one registered valid/ready command.
// Optional inverse-FFT support (conjugated twiddles, extra 'inv' input) is built
// when the macro FFT_SEQ_IFFT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; counters parked at 0
// RUN   | issuing commands; stays here until the final command is accepted
// GAP   | STAGE_GAP bubble cycles between stages; no new loads

module fft_twiddle_seq #(
    parameter int unsigned STAGE_GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef FFT_SEQ_IFFT_EN
    input  logic        inv,
`endif
    output logic        busy,
    output logic        done,
    output logic [2:0]  w_addr,
    input  logic [31:0] w_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_stage,
    output logic [3:0]  out_top,
    output logic [3:0]  out_bot,
    output logic [31:0] out_w,
    output logic        out_last
);

    localparam bit         GAP_EN   = (STAGE_GAP != 0);
    localparam logic [3:0] GAP_LOAD = (STAGE_GAP == 0) ? 4'd0 : 4'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  stg_q;
    logic [2:0]  bfly_q;
    logic [3:0]  gap_q;

    logic        valid_q, last_q, done_q;
    logic [1:0]  stage_q;
    logic [3:0]  top_q, bot_q;
    logic [31:0] w_q;

    logic [3:0]  span, span_m1;
    logic [2:0]  grp, kk, shamt;
    logic [7:0]  base;
    logic [3:0]  top_idx, bot_idx;
    logic [31:0] w_eff;

    logic        load, xfer, final_xfer, stage_end, is_last_bfly;

    // Operand indices and twiddle address for the butterfly selected by (stg_q, bfly_q)
    always_comb begin
        span    = 4'd8 >> stg_q;
        span_m1 = span - 4'd1;
        shamt   = 3'd3 - {1'b0, stg_q};
        grp     = bfly_q >> shamt;
        kk      = bfly_q & span_m1[2:0];
        // g*2*span is a shift because span is a power of two
        base    = {5'd0, grp} << (3'd4 - {1'b0, stg_q});
        top_idx = base[3:0] + {1'b0, kk};
        bot_idx = top_idx + span;
        w_addr  = kk << stg_q;
    end

`ifdef FFT_SEQ_IFFT_EN
    logic        inv_q;
    logic [15:0] im_neg;

    // Frame-wide inverse flag, latched only when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            inv_q <= inv;
        end
    end

    // Conjugate twiddle for inverse transforms; |im| <= 16384 so negation cannot overflow
    always_comb begin
        im_neg = 16'd0 - w_data[15:0];
        w_eff  = inv_q ? {w_data[31:16], im_neg} : w_data;
    end
`else
    // Forward transform only: twiddle passes through untouched
    always_comb begin
        w_eff = w_data;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and load/transfer decode
    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        xfer         = valid_q && out_ready;
        final_xfer   = xfer && last_q;
        stage_end    = (bfly_q == 3'd7) && (stg_q != 2'd3);
        is_last_bfly = (bfly_q == 3'd7) && (stg_q == 2'd3);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (final_xfer) begin
                    state_d = IDLE;
                end else if ((!valid_q || out_ready) && !(valid_q && last_q)) begin
                    // Once the last command is pending nothing more is loaded
                    load = 1'b1;
                    if (stage_end && GAP_EN) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage/butterfly counters and the inter-stage gap down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q  <= 2'd0;
            bfly_q <= 3'd0;
            gap_q  <= 4'd0;
        end else begin
            if (final_xfer) begin
                stg_q  <= 2'd0;
                bfly_q <= 3'd0;
            end else if (load) begin
                bfly_q <= bfly_q + 3'd1;
                if (stage_end) begin
                    stg_q <= stg_q + 2'd1;
                end
            end
            if (load && stage_end && GAP_EN) begin
                gap_q <= GAP_LOAD;
            end else if (state_q == GAP && gap_q != 4'd0) begin
                gap_q <= gap_q - 4'd1;
            end
        end
    end

    // Command output register with valid/ready hold, plus the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            stage_q <= 2'd0;
            top_q   <= 4'd0;
            bot_q   <= 4'd0;
            w_q     <= 32'd0;
        end else begin
            done_q <= final_xfer;
            if (load) begin
                valid_q <= 1'b1;
                stage_q <= stg_q;
                top_q   <= top_idx;
                bot_q   <= bot_idx;
                w_q     <= w_eff;
                last_q  <= is_last_bfly;
            end else if (xfer) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_stage = stage_q;
    assign out_top   = top_q;
    assign out_bot   = bot_q;
    assign out_w     = w_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// tb_fft_twiddle_seq - scoreboard bench for fft_twiddle_seq.
// Instance 0 uses STAGE_GAP=0, instance 1 uses STAGE_GAP=3. Build with
// FFT_SEQ_IFFT_EN defined to also exercise the conjugate-twiddle frame.

module tb_fft_twiddle_seq;

    typedef struct packed {
        logic [1:0]  stage;
        logic [3:0]  top;
        logic [3:0]  bot;
        logic [31:0] w;
        logic        last;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_a   [2];
    logic        start_a [2];
    logic        inv_a   [2];
    logic        ready_a [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic        valid_a [2];
    logic        last_a  [2];
    logic [2:0]  waddr_a [2];
    logic [31:0] wdata_a [2];
    logic [31:0] w_a     [2];
    logic [1:0]  stage_a [2];
    logic [3:0]  top_a   [2];
    logic [3:0]  bot_a   [2];

    logic [31:0] lut [8];

    cmd_t q0[$];
    cmd_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   exp_done[2];
    bit   stalled [2];
    cmd_t snap    [2];
    int   nxfer   [2];
    bit   cur_inv [2];
    bit   rmode   [2];
    int   t0      [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Twiddle LUT: combinational response to each instance's address
    assign wdata_a[0] = lut[waddr_a[0]];
    assign wdata_a[1] = lut[waddr_a[1]];

    fft_twiddle_seq #(.STAGE_GAP(0)) dut0 (
        .clk(clk), .rst(rst_a[0]), .start(start_a[0]),
`ifdef FFT_SEQ_IFFT_EN
        .inv(inv_a[0]),
`endif
        .busy(busy_a[0]), .done(done_a[0]), .w_addr(waddr_a[0]), .w_data(wdata_a[0]),
        .out_valid(valid_a[0]), .out_ready(ready_a[0]), .out_stage(stage_a[0]),
        .out_top(top_a[0]), .out_bot(bot_a[0]), .out_w(w_a[0]), .out_last(last_a[0])
    );

    fft_twiddle_seq #(.STAGE_GAP(3)) dut1 (
        .clk(clk), .rst(rst_a[1]), .start(start_a[1]),
`ifdef FFT_SEQ_IFFT_EN
        .inv(inv_a[1]),
`endif
        .busy(busy_a[1]), .done(done_a[1]), .w_addr(waddr_a[1]), .w_data(wdata_a[1]),
        .out_valid(valid_a[1]), .out_ready(ready_a[1]), .out_stage(stage_a[1]),
        .out_top(top_a[1]), .out_bot(bot_a[1]), .out_w(w_a[1]), .out_last(last_a[1])
    );

    // Ready driver: changes just after each rising edge, random when backpressure is on
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            ready_a[d] = rmode[d] ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic cmd_t cur(input int d);
        cmd_t c;
        c.stage = stage_a[d];
        c.top   = top_a[d];
        c.bot   = bot_a[d];
        c.w     = w_a[d];
        c.last  = last_a[d];
        return c;
    endfunction

    // Reference schedule: for each stage, every index whose span-block is even pairs
    // with index+span, and its twiddle exponent is (index mod span) * 2^stage.
    task automatic push_frame(input int d, input bit inv);
        cmd_t        e;
        int          span;
        int          n;
        logic [31:0] w;
        for (int s = 0; s < 4; s++) begin
            span = 8 >> s;
            for (int i = 0; i < 16; i++) begin
                if (((i / span) % 2) == 0) begin
                    n = (i % span) * (1 << s);
                    w = lut[n];
                    if (inv) w = {w[31:16], 16'd0 - w[15:0]};
                    e.stage = 2'(s);
                    e.top   = 4'(i);
                    e.bot   = 4'(i + span);
                    e.w     = w;
                    e.last  = (s == 3) && (i == 14);
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
    endtask

    task automatic mon(input int d);
        cmd_t g;
        cmd_t e;
        int   sz;
        g = cur(d);
        if (stalled[d])
            chk(valid_a[d] && (g == snap[d]), "hold_stable",
                {20'd0, valid_a[d], g}, {20'd0, 1'b1, snap[d]});
        stalled[d] = valid_a[d] && !ready_a[d];
        snap[d]    = g;
        if (exp_done[d]) begin
            chk(done_a[d] && !busy_a[d] && !valid_a[d], "done_pulse",
                64'({done_a[d], busy_a[d], valid_a[d]}), 64'h4);
            exp_done[d] = 1'b0;
        end else begin
            chk(!done_a[d], "done_unexpected", 64'(done_a[d]), 64'h0);
        end
        if (valid_a[d] && ready_a[d]) begin
            nxfer[d]++;
            sz = (d == 0) ? q0.size() : q1.size();
            chk(sz > 0, "cmd_unexpected", 64'(g), 64'h0);
            if (sz > 0) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk(g == e, "cmd", 64'(g), 64'(e));
                if (!cur_inv[d]) begin
                    if (e.stage == 2'd0 && e.top == 4'd3)
                        chk(g.bot == 4'd11 && g.w == 32'h187EC4DF, "s0b3", 64'({g.bot, g.w}), 64'({4'd11, 32'h187EC4DF}));
                    if (e.stage == 2'd1 && e.top == 4'd9)
                        chk(g.bot == 4'd13 && g.w == 32'h2D41D2BF, "s1b5", 64'({g.bot, g.w}), 64'({4'd13, 32'h2D41D2BF}));
                    if (e.stage == 2'd2 && e.top == 4'd1)
                        chk(g.bot == 4'd3 && g.w == 32'h0000C000, "s2b1", 64'({g.bot, g.w}), 64'({4'd3, 32'h0000C000}));
                    if (e.stage == 2'd3 && e.top == 4'd14)
                        chk(g.bot == 4'd15 && g.w == 32'h40000000 && g.last, "s3b7",
                            64'({g.last, g.bot, g.w}), 64'({1'b1, 4'd15, 32'h40000000}));
                end else if (e.stage == 2'd0 && e.top == 4'd3) begin
                    chk(g.w == 32'h187E3B21, "s0b3_inv", 64'(g.w), 64'h187E3B21);
                end
                if (e.last) exp_done[d] = 1'b1;
            end
        end
    endtask

    // Monitor: observe both instances on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_a[d] === 1'b0) mon(d);
            end
        end
    end

    // Issue start at a falling edge and queue the expected frame
    task automatic run_frame(input int d, input bit inv);
        start_a[d] = 1'b1;
        inv_a[d]   = inv;
        cur_inv[d] = inv;
        push_frame(d, inv);
        @(negedge clk);
        start_a[d] = 1'b0;
        inv_a[d]   = 1'b0;
        t0[d]      = cyc;
    endtask

    // Returns at the falling edge of the done cycle
    task automatic wait_done(input int d, input int exp_span);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_a[d]) begin
                seen = 1'b1;
                break;
            end
        end
        chk(seen, "done_timeout", 64'(seen), 64'h1);
        if (seen && exp_span > 0)
            chk((cyc - t0[d]) == exp_span, "frame_span", 64'(cyc - t0[d]), 64'(exp_span));
    endtask

    task automatic chk_zero(input int d, input string nm);
        chk({busy_a[d], done_a[d], valid_a[d], stage_a[d], top_a[d], bot_a[d], last_a[d]} == 15'd0,
            nm, 64'({busy_a[d], done_a[d], valid_a[d], stage_a[d], top_a[d], bot_a[d], last_a[d]}), 64'h0);
        chk(w_a[d] == 32'd0 && waddr_a[d] == 3'd0, {nm, "_w"}, 64'({waddr_a[d], w_a[d]}), 64'h0);
    endtask

    initial begin
        int base;
        lut[0] = 32'h40000000; lut[1] = 32'h3B21E782;
        lut[2] = 32'h2D41D2BF; lut[3] = 32'h187EC4DF;
        lut[4] = 32'h0000C000; lut[5] = 32'hE782C4DF;
        lut[6] = 32'hD2BFD2BF; lut[7] = 32'hC4DFE782;
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b1; start_a[d] = 1'b0; inv_a[d] = 1'b0;
            rmode[d] = 1'b0; exp_done[d] = 1'b0; stalled[d] = 1'b0;
            cur_inv[d] = 1'b0; nxfer[d] = 0; t0[d] = 0;
        end
        repeat (3) @(negedge clk);
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;
        @(negedge clk);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");

        // Unstalled frame, no gap: 32 consecutive commands, done 33 cycles after start
        run_frame(0, 1'b0);
        wait_done(0, 33);
        repeat (2) @(negedge clk);

        // Random backpressure with an ignored start mid-frame
        rmode[0] = 1'b1;
        run_frame(0, 1'b0);
        repeat (15) @(negedge clk);
        chk(busy_a[0], "busy_mid_frame", 64'(busy_a[0]), 64'h1);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        wait_done(0, 0);
        rmode[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back: start in the done cycle
        run_frame(0, 1'b0);
        wait_done(0, 33);
        run_frame(0, 1'b0);
        wait_done(0, 33);
        repeat (2) @(negedge clk);

        // Reset after ten commands, then a clean full frame
        run_frame(0, 1'b0);
        base = nxfer[0];
        for (int i = 0; i < 200 && (nxfer[0] - base) < 10; i++) @(negedge clk);
        rst_a[0] = 1'b1;
        @(negedge clk);
        chk_zero(0, "midreset");
        rst_a[0]    = 1'b0;
        q0.delete();
        exp_done[0] = 1'b0;
        stalled[0]  = 1'b0;
        repeat (5) @(negedge clk);
        run_frame(0, 1'b0);
        wait_done(0, 33);
        repeat (2) @(negedge clk);

        // STAGE_GAP=3 instance: 9 bubble cycles, then with backpressure
        run_frame(1, 1'b0);
        wait_done(1, 42);
        repeat (2) @(negedge clk);
        rmode[1] = 1'b1;
        run_frame(1, 1'b0);
        wait_done(1, 0);
        rmode[1] = 1'b0;
        repeat (2) @(negedge clk);

`ifdef FFT_SEQ_IFFT_EN
        // Inverse frame followed by a forward frame (inv must not persist)
        run_frame(0, 1'b1);
        wait_done(0, 33);
        repeat (2) @(negedge clk);
        run_frame(0, 1'b0);
        wait_done(0, 33);
`endif

        repeat (3) @(negedge clk);
        chk(q0.size() == 0 && q1.size() == 0, "sb_drained",
            64'({q0.size(), q1.size()}), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_twiddle_seq.md
Name: fft_twiddle_seq

Overview:
Butterfly schedule sequencer for the 16-point radix-2 DIF FFT core. On a start pulse it walks 4 stages × 8 butterflies. For each butterfly it drives the twiddle LUT address, captures the returned Q1.14 complex twiddle, and presents the result as one registered command on a valid/ready interface. The butterfly datapath consumes these commands. This block is the initiator and consumer on the twiddle-LUT address/data interface.

Parameters:
STAGE_GAP, 0, bubble cycles inserted after the last butterfly of stages 0..2 (legal range 0..15); used for datapath memory-hazard clearance.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to run one FFT frame schedule; honoured only in IDLE
busy  output  1  high while a schedule is in progress (state != IDLE)
done  output  1  one-cycle pulse after the final command handshake
w_addr  output  3  twiddle LUT address; combinational from current counters
w_data  input  32  twiddle from LUT, {re[15:0], im[15:0]}, signed Q1.14, combinational response to w_addr
out_valid  output  1  command valid
out_ready  input  1  datapath accepts command
out_stage  output  2  stage 0..3
out_top  output  4  upper butterfly operand index
out_bot  output  4  lower butterfly operand index
out_w  output  32  twiddle for this butterfly, {re, im}
out_last  output  1  high on final command (stage 3, butterfly 7)

Behaviour:
- Reset: state IDLE, counters 0, gap counter 0. Outputs: busy=0, done=0, out_valid=0, out_stage=0, out_top=0, out_bot=0, out_w=0, out_last=0.
- States: IDLE, RUN, GAP.
- IDLE + start → RUN; stage counter s=0, butterfly counter b=0. start outside IDLE is ignored.
- Index math, with span = 8>>s, g = b>>(3-s), k = b & (span-1):
  - top = g*2*span + k
  - bot = top + span
  - w_addr = k<<s (always < 8)
- Load condition, RUN only: (!out_valid || out_ready). On load:
  - output register ← {s, top, bot, w_data, last}
  - out_valid=1
  - b increments.
- If b=7 and s<3, b wraps to 0 and s increments. If STAGE_GAP>0, next state is GAP.
- If b=7 and s=3, no further loads. State stays RUN until the final handshake.
- GAP: counts STAGE_GAP cycles, then returns to RUN. No loads occur during GAP.
- The pending output may still be accepted during GAP; out_valid drops to 0 on acceptance when no new load occurs.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, all out_* hold stable.
  - out_valid never drops without a transfer.
- Throughput: with out_ready held 1 and STAGE_GAP=0, 32 commands arrive on 32 consecutive cycles. The first out_valid appears in the cycle after start is sampled.
- End of frame: at the edge of the final transfer (out_last=1):
  - out_valid←0
  - done←1 for exactly one cycle
  - busy←0
  - state←IDLE
- start asserted in the done cycle is accepted; back-to-back frames are legal.
- rst mid-frame: immediate return to reset values on the next edge. No done pulse; the pending command is discarded.
- out_w is a registered copy of w_data. No arithmetic on w_data except under the optional feature.

Optional Feature:
- Macro: FFT_SEQ_IFFT_EN.
- When defined:
  - Adds input port inv (1 bit), sampled only when start is accepted and held for the whole frame.
  - With inv=1, out_w = {re, -im} (conjugate twiddle, inverse FFT). Two's complement negate of 16 bits.
  - Imag range −16384..0 → 0..16384, so there is no overflow.
- When undefined: no inv port; out_w = w_data unmodified.

Test Plan:
- Reset then start, out_ready=1, STAGE_GAP=0 → 32 commands on consecutive cycles.
  - 4th command (s0,b3): top=3, bot=11, w_addr=3, out_w=0x187EC4DF.
  - done one cycle after the out_last transfer.
- Stage 1 butterfly 5 → top=9, bot=13, w_addr=2, out_w=0x2D41D2BF.
- Stage 2 butterfly 1 → top=1, bot=3, w_addr=4, out_w=0x0000C000.
- Stage 3 butterfly 7 → top=14, bot=15, out_w=0x40000000, out_last=1.
- Random out_ready backpressure → outputs stable while stalled; the 32-entry sequence is identical to the unstalled run.
- STAGE_GAP=3:
  - exactly 3 cycles of no new load between stages.
  - with out_ready=1, the total start-to-done span is 33+9 cycles.
- rst asserted at command 10 → next cycle all outputs 0, no done pulse.
  - a new start then yields the full 32 commands from s0,b0.
- start asserted while busy → ignored; start in the done cycle → new frame begins.
- FFT_SEQ_IFFT_EN with inv=1 → s0,b3 out_w=0x187E3B21.
